knight_rider_ctrl: RTL and testbench
====================================

Name: knight_rider_ctrl

Overview:
Run controller for the `knight_rider` LED-sweep datapath.
- Holds the datapath in reset while idle.
- Generates its step strobe at a programmable rate.
- Counts completed sweeps by watching the LED bus, and stops after a programmed number of sweeps.
- Sits between the top-level switches/buttons and `knight_rider`: drives its `reset` and `enable`, observes its `leds`.

Parameters:
- WIDTH, 8: width of the observed LED bus.
- DIV_BASE, 1000000: base prescaler period in clk cycles; effective step period = DIV_BASE*(speed_q+1).
- SPEED_W, 3: width of speed_sel.
- CNT_W, 8: width of num_sweeps and sweep_count.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  start/restart request (sampled each cycle)
- stop  in  1  abort request, returns to IDLE
- pause  in  1  level; freezes stepping while high in RUN
- speed_sel  in  SPEED_W  step rate select, latched on start
- num_sweeps  in  CNT_W  sweeps to run, latched on start; 0 = run forever
- leds_in  in  WIDTH  LED bus from datapath
- kr_reset  out  1  datapath reset
- kr_enable  out  1  one-cycle step strobe to datapath
- busy  out  1  high in RUN and PAUSE
- done  out  1  high in DONE
- sweep_count  out  CNT_W  completed sweeps since last start

Behaviour:
- Reset values (async): state=IDLE, kr_reset=1, kr_enable=0, busy=0, done=0, sweep_count=0, prescaler=0, speed_q=0, nsw_q=0, ep_d=1.
- All outputs are registered.
- Command priority each cycle: stop > start > pause.
- States:
  - IDLE: kr_reset=1, kr_enable=0.
    - start&~stop → RUN next cycle.
    - On that edge: latch speed_q, nsw_q; clear sweep_count and prescaler; set ep_d=1.
  - RUN: kr_reset=0.
    - prescaler counts 0..P-1 with P=DIV_BASE*(speed_q+1), then wraps.
    - kr_enable=1 for exactly the one cycle after prescaler==P-1.
    - pause=1 → PAUSE.
    - stop → IDLE.
    - start → restart: same actions as the IDLE→RUN edge, stays in RUN.
  - PAUSE: kr_reset=0, kr_enable=0; prescaler and sweep_count held.
    - pause=0 → RUN; the prescaler continues from its held value.
    - stop → IDLE.
    - start → restart into RUN.
  - DONE: kr_reset=0 (pattern frozen), kr_enable=0, done=1.
    - start → restart into RUN.
    - stop → IDLE, which clears done.
- Sweep detection:
  - ep = leds_in[0] | leds_in[WIDTH-1]; ep_d <= ep every cycle, except when preloaded to 1 on start.
  - In RUN, ep&~ep_d increments sweep_count. sweep_count saturates at 2^CNT_W-1.
  - Preloading ep_d=1 means the initial endpoint LED present after the datapath leaves reset is not counted.
- Termination:
  - If nsw_q≠0 and the increment makes sweep_count==nsw_q, go to DONE on the same edge.
  - The kr_enable strobe scheduled for that edge is suppressed.
  - If nsw_q==0, the block never enters DONE by counting.
- speed_sel and num_sweeps changes outside the start edge have no effect.
- Reset asserted mid-operation returns everything to the reset values immediately.

Optional Feature:
- Macro: KRC_AUTO_REPEAT_EN.
- Defined: DONE is transient.
  - The cycle after entering DONE, the block performs a restart into RUN with the latched speed_q and nsw_q; inputs are not re-sampled.
  - done pulses high for exactly one cycle per completed run.
  - stop in the DONE cycle still wins → IDLE.
- Not defined: DONE holds as described in Behaviour.

Test Plan:
- Bench settings: WIDTH=8, DIV_BASE=4, CNT_W=8.
- Reset held 2 cycles, then released with no start → kr_reset=1, kr_enable=0, busy=0, done=0, sweep_count=0 indefinitely.
- start pulse, speed_sel=0, num_sweeps=0 → busy=1, kr_reset=0 next cycle; kr_enable pulses every 4 cycles; speed_sel=2 on start → every 12 cycles.
- start with num_sweeps=2; drive leds_in 01→…→80→…→01 → sweep_count steps 1 at 0x80, 2 at the return to 0x01; DONE on the second edge; done=1, busy=0, no further kr_enable.
- pause=1 for 20 cycles mid-RUN → no kr_enable while paused; after release, first strobe arrives (P − held prescaler) cycles later; sweep_count unchanged.
- start and stop asserted together in RUN → IDLE, kr_reset=1; stop in PAUSE → IDLE.
- With KRC_AUTO_REPEAT_EN, num_sweeps=1 → done is a single-cycle pulse after each sweep; sweep_count returns to 0 and stepping resumes.

Source files
------------

// File: rtl/knight_rider_ctrl.sv
// knight_rider_ctrl: run controller for knight_rider (datapath reset, step strobe, sweep count, auto-stop).
// Registered outputs, one-cycle command latency. Define KRC_AUTO_REPEAT_EN to make DONE restart the run automatically.
module knight_rider_ctrl #(
  parameter int WIDTH    = 8,
  parameter int DIV_BASE = 1000000,
  parameter int SPEED_W  = 3,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic [SPEED_W-1:0] speed_sel,
  input  logic [CNT_W-1:0]   num_sweeps,
  input  logic [WIDTH-1:0]   leds_in,
  output logic               kr_reset,
  output logic               kr_enable,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sweep_count
);

  localparam int PMAX = DIV_BASE * (2 ** SPEED_W);
  localparam int PW   = $clog2(PMAX + 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [CNT_W-1:0]   nsw_q, nsw_d;
  logic [CNT_W-1:0]   sweep_count_q, sweep_count_d;
  logic               ep_dly_q, ep_dly_d;
  logic               kr_reset_q, kr_reset_d;
  logic               kr_enable_q, kr_enable_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               ep;
  logic               restart;
  logic               auto_restart;
  logic [PW-1:0]      period_m1;
  logic               leds_unused;

  assign ep          = leds_in[0] | leds_in[WIDTH-1];
  assign leds_unused = ^leds_in[WIDTH-2:1];
  assign period_m1   = PW'(DIV_BASE * (int'(speed_q) + 1) - 1);

  always_comb begin
    state_d       = state_q;
    presc_d       = presc_q;
    speed_d       = speed_q;
    nsw_d         = nsw_q;
    sweep_count_d = sweep_count_q;
    ep_dly_d      = ep;
    kr_enable_d   = 1'b0;
    restart       = 1'b0;
    auto_restart  = 1'b0;

    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      restart = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          // Rising edge of "an endpoint LED is lit" marks one completed sweep.
          if (ep && !ep_dly_q && (sweep_count_q != '1)) begin
            sweep_count_d = sweep_count_q + CNT_W'(1);
            if ((nsw_q != '0) && (sweep_count_d == nsw_q)) state_d = DONE;
          end
          if (state_d != DONE) begin
            if (pause) begin
              state_d = PAUSE;
            end else if (presc_q == period_m1) begin
              presc_d     = '0;
              kr_enable_d = 1'b1;
            end else begin
              presc_d = presc_q + PW'(1);
            end
          end
        end
        PAUSE: begin
          if (!pause) state_d = RUN;
        end
        DONE: begin
`ifdef KRC_AUTO_REPEAT_EN
          auto_restart = 1'b1;
`else
          auto_restart = 1'b0;
`endif
        end
        default: ;
      endcase
    end

    if (restart) begin
      speed_d = speed_sel;
      nsw_d   = num_sweeps;
    end
    // Preloading ep_dly hides the endpoint LED the datapath shows right after reset.
    if (restart || auto_restart) begin
      state_d       = RUN;
      presc_d       = '0;
      sweep_count_d = '0;
      ep_dly_d      = 1'b1;
    end

    kr_reset_d = (state_d == IDLE);
    busy_d     = (state_d == RUN) || (state_d == PAUSE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      presc_q       <= '0;
      speed_q       <= '0;
      nsw_q         <= '0;
      sweep_count_q <= '0;
      ep_dly_q      <= 1'b1;
      kr_reset_q    <= 1'b1;
      kr_enable_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      speed_q       <= speed_d;
      nsw_q         <= nsw_d;
      sweep_count_q <= sweep_count_d;
      ep_dly_q      <= ep_dly_d;
      kr_reset_q    <= kr_reset_d;
      kr_enable_q   <= kr_enable_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign kr_reset    = kr_reset_q;
  assign kr_enable   = kr_enable_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign sweep_count = sweep_count_q;

endmodule

// File: tb/tb_knight_rider_ctrl.sv
// Bench for knight_rider_ctrl: directed phases plus random commands, checked every cycle against a behavioural model.
module tb_knight_rider_ctrl;

  localparam int WIDTH = 8;
  localparam int DIV   = 4;
  localparam int SPW   = 3;
  localparam int CW    = 8;

  logic             clk;
  logic             reset;
  logic             start;
  logic             stop;
  logic             pause;
  logic [SPW-1:0]   speed_sel;
  logic [CW-1:0]    num_sweeps;
  logic [WIDTH-1:0] leds_in;
  logic             kr_reset;
  logic             kr_enable;
  logic             busy;
  logic             done;
  logic [CW-1:0]    sweep_count;

  knight_rider_ctrl #(.WIDTH(WIDTH), .DIV_BASE(DIV), .SPEED_W(SPW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .speed_sel(speed_sel), .num_sweeps(num_sweeps), .leds_in(leds_in),
    .kr_reset(kr_reset), .kr_enable(kr_enable), .busy(busy), .done(done),
    .sweep_count(sweep_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: mode 0=idle 1=run 2=pause 3=done; ticks = running cycles since last strobe.
  int m_mode, m_cnt, m_ticks, m_period, m_nsw;
  bit m_prev, m_en;
  int en_seen, done_seen;

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_ticks = 0; m_period = DIV; m_nsw = 0; m_prev = 1; m_en = 0;
  endtask

  task automatic model_step();
    bit ep, rise, finished;
    if (reset) begin
      model_reset();
      return;
    end
    ep     = leds_in[0] | leds_in[WIDTH-1];
    rise   = ep && !m_prev;
    m_prev = ep;
    m_en   = 0;
    if (stop) begin
      m_mode = 0;
    end else if (start) begin
      m_mode = 1; m_period = DIV * (int'(speed_sel) + 1); m_nsw = int'(num_sweeps);
      m_cnt = 0; m_ticks = 0; m_prev = 1;
    end else if (m_mode == 1) begin
      finished = 0;
      if (rise && m_cnt < 255) begin
        m_cnt++;
        finished = (m_nsw != 0) && (m_cnt == m_nsw);
      end
      if (finished) m_mode = 3;
      else if (pause) m_mode = 2;
      else begin
        m_ticks++;
        if (m_ticks == m_period) begin
          m_en = 1;
          m_ticks = 0;
        end
      end
    end else if (m_mode == 2) begin
      if (!pause) m_mode = 1;
    end else if (m_mode == 3) begin
`ifdef KRC_AUTO_REPEAT_EN
      m_mode = 1; m_cnt = 0; m_ticks = 0; m_prev = 1;
`endif
    end
  endtask

  task automatic compare_all();
    check("kr_reset", kr_reset, m_mode == 0);
    check("kr_enable", kr_enable, m_en);
    check("busy", busy, (m_mode == 1) || (m_mode == 2));
    check("done", done, m_mode == 3);
    check("sweep_count", sweep_count, m_cnt);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    if (kr_enable) en_seen++;
    if (done) done_seen++;
  endtask

  task automatic do_start(input int spd, input int nsw);
    start = 1; speed_sel = SPW'(spd); num_sweeps = CW'(nsw);
    cycle();
    start = 0;
  endtask

  // One full back-and-forth pass starting from LED0, each position held 'hold' cycles.
  task automatic walk(input int hold);
    int pos;
    for (int k = 0; k < 15; k++) begin
      pos = (k < 8) ? k : 14 - k;
      leds_in = WIDTH'(1 << pos);
      repeat (hold) cycle();
    end
  endtask

  int held, gap;
  int pos_r, dir_r;

  initial begin
    reset = 1; start = 0; stop = 0; pause = 0;
    speed_sel = '0; num_sweeps = '0; leds_in = 8'h01;
    en_seen = 0; done_seen = 0;
    model_reset();
    #1 compare_all();
    repeat (2) cycle();
    reset = 0;

    // Idle with random LEDs and no start.
    for (int i = 0; i < 10; i++) begin
      leds_in = WIDTH'($urandom_range(0, 255));
      cycle();
    end

    // Free-running at speed 0, then speed 2.
    leds_in = 8'h01;
    do_start(0, 0);
    en_seen = 0;
    repeat (40) cycle();
    check("strobes_p4", en_seen, 10);
    do_start(2, 0);
    en_seen = 0;
    repeat (48) cycle();
    check("strobes_p12", en_seen, 4);

    // Two sweeps then DONE.
    leds_in = 8'h01;
    do_start(0, 2);
    for (int k = 1; k < 8; k++) begin
      leds_in = WIDTH'(1 << k);
      repeat (2) cycle();
    end
    check("count_at_80", sweep_count, 1);
    for (int k = 6; k >= 0; k--) begin
      leds_in = WIDTH'(1 << k);
      repeat (2) cycle();
    end
    check("count_done", sweep_count, 2);
    check("done_hold", done, 1'b1);
    en_seen = 0;
    repeat (12) cycle();
`ifndef KRC_AUTO_REPEAT_EN
    check("no_strobe_done", en_seen, 0);
    check("busy_done", busy, 1'b0);
`endif

    // Pause mid-run.
    leds_in = 8'h01;
    do_start(0, 0);
    repeat (5) cycle();
    pause = 1;
    cycle();
    held = m_ticks;
    en_seen = 0;
    repeat (20) cycle();
    check("no_strobe_paused", en_seen, 0);
    check("count_paused", sweep_count, 0);
    pause = 0;
    gap = 0;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      if (kr_enable) begin
        gap = k - 1;
        break;
      end
    end
    check("resume_gap", gap, DIV - held);

    // start+stop together in RUN, then stop from PAUSE.
    repeat (3) cycle();
    start = 1; stop = 1;
    cycle();
    start = 0; stop = 0;
    check("startstop_idle", kr_reset, 1'b1);
    do_start(1, 0);
    pause = 1;
    repeat (3) cycle();
    stop = 1;
    cycle();
    stop = 0; pause = 0;
    check("stop_pause_idle", kr_reset, 1'b1);
    check("stop_pause_busy", busy, 1'b0);

`ifdef KRC_AUTO_REPEAT_EN
    leds_in = 8'h01;
    do_start(0, 1);
    done_seen = 0;
    walk(2);
    check("auto_done_pulses", done_seen, 2);
    repeat (3) cycle();
    check("auto_busy", busy, 1'b1);
`endif

    // Random commands and LED activity.
    pos_r = 0; dir_r = 1;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        #2 reset = 1;
        #1 model_reset();
        compare_all();
        cycle();
        reset = 0;
      end
      start = ($urandom_range(0, 49) == 0);
      stop  = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 19) == 0) pause = ~pause;
      speed_sel  = SPW'($urandom_range(0, 7));
      num_sweeps = CW'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) begin
        leds_in = WIDTH'($urandom_range(0, 255));
      end else begin
        if ($urandom_range(0, 2) == 0) begin
          if ((pos_r == 7 && dir_r == 1) || (pos_r == 0 && dir_r == -1)) dir_r = -dir_r;
          pos_r = pos_r + dir_r;
        end
        leds_in = WIDTH'(1 << pos_r);
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
